// File: rtl/present_fall_ctrl.sv
// Per-frame gravity mover for a falling present: drift, wall reflection, floor land/bounce, blink, despawn.
// All outputs are registered one clock after the input event; there is no backpressure because inputs are single-cycle pulses.
module present_fall_ctrl #(
   parameter int G              = 1,
   parameter int MULT_SHIFT     = 6,
   parameter int FRAME_W        = 640,
   parameter int FRAME_H        = 480,
   parameter int PRESENT_WIDTH  = 20,
   parameter int PRESENT_HEIGHT = 20,
   parameter int MAX_YSPEED     = 256,
   parameter int BOUNCE_EN      = 0,
   parameter int BOUNCE_SHIFT   = 1,
   parameter int MIN_BOUNCE     = 32,
   parameter int LAND_FRAMES    = 90,
   parameter int BLINK_FRAMES   = 30,
   parameter int BLINK_PERIOD   = 4
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic               spawn,
   input  logic [10:0]        spawnX,
   input  logic [10:0]        spawnY,
   input  logic signed [15:0] spawnXspeed,
   input  logic signed [15:0] spawnYspeed,
   input  logic               collected,
   output logic [10:0]        topLeftX,
   output logic [10:0]        topLeftY,
   output logic               visible,
   output logic               busy,
   output logic               landed,
   output logic               despawnPulse,
   output logic               collectAck
);

   localparam logic signed [31:0] XMAX_FP  = 32'((FRAME_W - 1 - PRESENT_WIDTH) << MULT_SHIFT);
   localparam logic signed [31:0] FLOOR_FP = 32'((FRAME_H - 1 - PRESENT_HEIGHT) << MULT_SHIFT);
   localparam logic signed [31:0] G_FP     = 32'(G);
   localparam logic signed [31:0] MAX_YS   = 32'(MAX_YSPEED);
   localparam logic signed [31:0] MIN_BNC  = 32'(MIN_BOUNCE);
   localparam logic [15:0]        LAND_C   = 16'(LAND_FRAMES);
   localparam logic [15:0]        BLINK_C  = 16'(BLINK_FRAMES);
   localparam int                 BLINK_BIT = $clog2(BLINK_PERIOD);

   typedef enum logic [1:0] {IDLE, FALLING, LANDED} state_t;

   state_t             state_q, state_d;
   logic signed [31:0] x_q, x_d, y_q, y_d, xs_q, xs_d, ys_q, ys_d;
   logic signed [31:0] nx, ny, ys_g;
   logic [15:0]        cnt_q, cnt_d;
   logic [10:0]        tlx_d, tly_d;
   logic               vis_d, busy_d, landed_d, desp_d, ack_d;

   // Pixel coordinate of a fixed-point position; anything left/above the screen pins to 0.
   function automatic logic [10:0] to_pix(input logic signed [31:0] v);
      logic signed [31:0] s;
      s = v >>> MULT_SHIFT;
      to_pix = (v < 0) ? 11'd0 : s[10:0];
   endfunction

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      xs_d    = xs_q;
      ys_d    = ys_q;
      cnt_d   = cnt_q;
      desp_d  = 1'b0;
      ack_d   = 1'b0;
      nx      = x_q + xs_q;
      ny      = y_q + ys_q;
      ys_g    = ys_q + G_FP;

      case (state_q)
         IDLE: begin
            if (spawn) begin
               x_d     = 32'({21'd0, spawnX}) << MULT_SHIFT;
               y_d     = 32'({21'd0, spawnY}) << MULT_SHIFT;
               xs_d    = 32'(spawnXspeed);
               ys_d    = 32'(spawnYspeed);
               state_d = FALLING;
            end
         end
         FALLING: begin
            if (collected) begin
               state_d = IDLE;
               ack_d   = 1'b1;
            end else if (startOfFrame) begin
               if (nx < 0) begin
                  x_d  = '0;
                  xs_d = -xs_q;
               end else if (nx > XMAX_FP) begin
                  x_d  = XMAX_FP;
                  xs_d = -xs_q;
               end else begin
                  x_d = nx;
               end
               if (ny >= FLOOR_FP) begin
                  y_d = FLOOR_FP;
                  if (BOUNCE_EN != 0 && ys_q >= MIN_BNC) begin
                     ys_d = -(ys_q >>> BOUNCE_SHIFT);
                  end else begin
                     ys_d    = '0;
                     xs_d    = '0;
                     cnt_d   = LAND_C;
                     state_d = LANDED;
                  end
               end else begin
                  y_d  = ny;
                  ys_d = (ys_g > MAX_YS) ? MAX_YS : ys_g;
               end
            end
         end
         LANDED: begin
            if (collected) begin
               state_d = IDLE;
               ack_d   = 1'b1;
            end else if (startOfFrame) begin
               if (cnt_q <= 16'd1) begin
                  cnt_d   = '0;
                  state_d = IDLE;
                  desp_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q - 16'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d   = (state_d != IDLE);
      landed_d = (state_d == LANDED);
      case (state_d)
         FALLING: vis_d = 1'b1;
         LANDED:  vis_d = (cnt_d > BLINK_C) || !cnt_d[BLINK_BIT];
         default: vis_d = 1'b0;
      endcase
      tlx_d = to_pix(x_d);
      tly_d = to_pix(y_d);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q      <= IDLE;
         x_q          <= '0;
         y_q          <= '0;
         xs_q         <= '0;
         ys_q         <= '0;
         cnt_q        <= '0;
         topLeftX     <= '0;
         topLeftY     <= '0;
         visible      <= 1'b0;
         busy         <= 1'b0;
         landed       <= 1'b0;
         despawnPulse <= 1'b0;
         collectAck   <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         xs_q         <= xs_d;
         ys_q         <= ys_d;
         cnt_q        <= cnt_d;
         topLeftX     <= tlx_d;
         topLeftY     <= tly_d;
         visible      <= vis_d;
         busy         <= busy_d;
         landed       <= landed_d;
         despawnPulse <= desp_d;
         collectAck   <= ack_d;
      end
   end

endmodule

// File: doc/present_fall_ctrl.md
Name: present_fall_ctrl

Overview:
Parametrised gravity mover for a falling present sprite. Adds horizontal drift with wall reflection, a terminal velocity clamp, optional floor bounce, a landed/blink/despawn lifecycle and spawn/collect handshakes. Sits between the present spawner and the present draw/collision logic. Updates once per startOfFrame.

Parameters:
G, 1, gravity added to Yspeed per frame (fixed-point units)
MULT_SHIFT, 6, fixed-point fraction bits (multiplier = 2^MULT_SHIFT)
FRAME_W, 640, screen width in pixels
FRAME_H, 480, screen height in pixels
PRESENT_WIDTH, 20, sprite width in pixels
PRESENT_HEIGHT, 20, sprite height in pixels
MAX_YSPEED, 256, terminal downward speed (fixed units)
BOUNCE_EN, 0, 1 = bounce on floor hit
BOUNCE_SHIFT, 1, bounce speed = -(Yspeed >>> BOUNCE_SHIFT)
MIN_BOUNCE, 32, minimum Yspeed that still bounces
LAND_FRAMES, 90, frames spent landed before despawn
BLINK_FRAMES, 30, final landed frames during which the sprite blinks
BLINK_PERIOD, 4, blink half-period in frames (power of 2)

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse per frame
spawn  in  1  one-cycle spawn request
spawnX, spawnY  in  11 each  spawn position in pixels
spawnXspeed, spawnYspeed  in  16 signed each  initial speeds (fixed units)
collected  in  1  one-cycle pulse when the player takes the present
topLeftX, topLeftY  out  11 each  sprite position in pixels
visible  out  1  draw enable
busy  out  1  state != IDLE
landed  out  1  state == LANDED
despawnPulse  out  1  one-cycle pulse on timeout
collectAck  out  1  one-cycle pulse on accepted collect

Behaviour:
- Reset (asynchronous, resetN low): state IDLE. Positions, speeds and counter are 0. All outputs are 0.
- Internal X, Y, Xspeed and Yspeed are 32-bit signed fixed point. XMAX_FP = (FRAME_W-1-PRESENT_WIDTH)<<MULT_SHIFT. FLOOR_FP = (FRAME_H-1-PRESENT_HEIGHT)<<MULT_SHIFT.
- topLeftX and topLeftY = internal value >>> MULT_SHIFT. A negative value outputs 0. Outputs are registered and follow the internal state on the next clock.
- IDLE: visible = 0. On spawn, load X = spawnX<<MULT_SHIFT, Y = spawnY<<MULT_SHIFT and both speeds, then go to FALLING. Motion starts at the next startOfFrame, even if startOfFrame coincides with spawn.
- Spawn outside IDLE is ignored. collected in IDLE is ignored, with no ack.
- FALLING: visible = 1. On startOfFrame:
  - nY = Y + Yspeed; nX = X + Xspeed.
  - X: if nX < 0, X = 0 and Xspeed is negated. If nX > XMAX_FP, X = XMAX_FP and Xspeed is negated. Otherwise X = nX.
  - If nY >= FLOOR_FP, Y = FLOOR_FP and gravity is not applied this frame. Then, if BOUNCE_EN and Yspeed >= MIN_BOUNCE, Yspeed = -(Yspeed >>> BOUNCE_SHIFT) and the state stays FALLING. Otherwise Yspeed = 0, Xspeed = 0, counter = LAND_FRAMES and the state goes to LANDED.
  - Otherwise Y = nY and Yspeed = min(Yspeed + G, MAX_YSPEED).
- LANDED: position is frozen and landed = 1. On startOfFrame the counter decrements. When the counter reaches 0: state goes to IDLE, despawnPulse is 1 for one cycle, visible = 0.
- LANDED visibility: visible = 1 if counter > BLINK_FRAMES. Otherwise visible = 1 only when bit log2(BLINK_PERIOD) of the counter is 0.
- collected in FALLING or LANDED: state goes to IDLE on the next clock, with collectAck = 1 for one cycle. collected has priority over a same-cycle startOfFrame, landing or timeout; despawnPulse is then not asserted.
- Reset asserted mid-flight returns to IDLE immediately, with no pulses.

Test Plan:
1. Spawn (100,0), speeds 0, then startOfFrame repeatedly -> Y_fp after n frames = n(n-1)/2. Landing occurs on frame 243 (29403 >= 29376): topLeftY = 459, landed = 1, topLeftX = 100 throughout.
2. Spawn Y=0, Yspeed=250, Xspeed=0 -> after 10 frames Yspeed = 256 (clamped), Y_fp = 2539, topLeftY = 39.
3. Spawn X=615, Xspeed=100, Y=0 -> X_fp goes 39460, 39560, then clamps to 39616 with Xspeed = -100. After frame 4, X_fp = 39516 and topLeftX = 617.
4. BOUNCE_EN=1, spawn Y=458, Yspeed=128 -> frame 1: Y = 29376, Yspeed = -64, still FALLING. Frame 2: Y_fp = 29312, topLeftY = 458, Yspeed = -63.
5. Land, then count frames -> visible = 1 through counter 31. visible = 0 at counter 30 and 28, visible = 1 at 27. despawnPulse occurs on the 90th startOfFrame after landing, then busy = 0.
6. collected coincident with startOfFrame mid-fall -> IDLE, collectAck for one cycle, position not updated. Spawn while busy is ignored. resetN low mid-LANDED gives all outputs 0 asynchronously.
